// File: rtl/antifurto_pkg.sv
// antifurto_pkg: interval codes, timer state codes and default delays shared with the anti-theft FSM
package antifurto_pkg;
    localparam logic [1:0] INT_ARM   = 2'b00;
    localparam logic [1:0] INT_DRV   = 2'b01;
    localparam logic [1:0] INT_PASS  = 2'b10;
    localparam logic [1:0] INT_ALARM = 2'b11;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] COUNT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam int T_ARM_DEFAULT   = 6;
    localparam int T_DRV_DEFAULT   = 8;
    localparam int T_PASS_DEFAULT  = 15;
    localparam int T_ALARM_DEFAULT = 10;
endpackage

// File: rtl/timer_antifurto_one_hz_gen.sv
// one_hz_gen: free-running divider producing a one-clock tick every CLK_FREQ_HZ clocks
module one_hz_gen #(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int DW = CLK_FREQ_HZ > 1 ? $clog2(CLK_FREQ_HZ) : 1;
    logic [DW-1:0] r_div;
    assign tick = r_div == DW'(CLK_FREQ_HZ - 1);
    always_ff @(posedge clock or negedge reset)
        if (!reset) r_div <= '0;
        else r_div <= (clear || tick) ? '0 : r_div + 1'b1;
endmodule

// File: rtl/timer_antifurto.sv
// timer_antifurto: programmable seconds countdown for the anti-theft FSM.
// Define TIMER_TICK_EXT_EN to take the 1 Hz tick from tick_in instead of the internal divider.
module timer_antifurto
    import antifurto_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TW          = 4,
    parameter int T_ARM_DEF   = T_ARM_DEFAULT,
    parameter int T_DRV_DEF   = T_DRV_DEFAULT,
    parameter int T_PASS_DEF  = T_PASS_DEFAULT,
    parameter int T_ALARM_DEF = T_ALARM_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start_timer,
    input  logic [1:0]    interval,
    input  logic          reprogram,
    input  logic [1:0]    time_param_sel,
    input  logic [TW-1:0] time_value,
`ifdef TIMER_TICK_EXT_EN
    input  logic          tick_in,
`endif
    output logic          expired,
    output logic          one_hz_enable,
    output logic          busy,
    output logic [TW-1:0] remaining
);
    logic [1:0]    r_state, w_next;
    logic [TW-1:0] r_count;
    logic [TW-1:0] r_param [4];
    logic          w_finish;
`ifdef TIMER_TICK_EXT_EN
    assign one_hz_enable = tick_in;
`else
    one_hz_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_one_hz_gen (
        .clock(clock),
        .reset(reset),
        .clear(start_timer),
        .tick (one_hz_enable)
    );
`endif
    // a zero load finishes without waiting for a tick
    assign w_finish  = r_count == '0 || (one_hz_enable && r_count == TW'(1));
    assign w_next    = start_timer ? LOAD :
                       r_state == LOAD ? COUNT :
                       r_state == COUNT ? (w_finish ? DONE : COUNT) : IDLE;
    assign expired   = r_state == DONE;
    assign busy      = r_state == LOAD || r_state == COUNT;
    assign remaining = busy ? r_count : '0;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (start_timer) r_count <= r_param[interval];
            else if (r_state == COUNT) r_count <= w_finish ? '0 : one_hz_enable ? r_count - 1'b1 : r_count;
        end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            r_param[INT_ARM]   <= TW'(T_ARM_DEF);
            r_param[INT_DRV]   <= TW'(T_DRV_DEF);
            r_param[INT_PASS]  <= TW'(T_PASS_DEF);
            r_param[INT_ALARM] <= TW'(T_ALARM_DEF);
        end else if (reprogram) r_param[time_param_sel] <= time_value;
endmodule

// File: tb/tb_timer_antifurto.sv
// tb_timer_antifurto: scoreboard bench, expected expiry cycles queued at each start
module tb_timer_antifurto;
    logic       clock = 0;
    logic       reset = 0;
    logic       start_timer = 0;
    logic [1:0] interval = 0;
    logic       reprogram = 0;
    logic [1:0] time_param_sel = 0;
    logic [3:0] time_value = 0;
    logic       expired, one_hz_enable, busy;
    logic [3:0] remaining;
    int n_chk = 0, n_err = 0, cyc = 0;
    int q[$];
    timer_antifurto #(.CLK_FREQ_HZ(10)) dut (
        .clock(clock), .reset(reset), .start_timer(start_timer), .interval(interval),
        .reprogram(reprogram), .time_param_sel(time_param_sel), .time_value(time_value),
        .expired(expired), .one_hz_enable(one_hz_enable), .busy(busy), .remaining(remaining)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    always @(negedge clock)
        if (reset && expired) begin
            if (q.size() == 0) chk("spurious_expired", cyc, -1);
            else chk("expired_cycle", cyc, q.pop_front());
        end
    task automatic start(input logic [1:0] i, input int dur, output int ld);
        start_timer = 1;
        interval = i;
        @(negedge clock);
        start_timer = 0;
        reprogram = 0;
        ld = cyc;
        q.push_back(ld + dur);
    endtask
    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask
    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            chk("expiry_timeout", q.size(), 0);
            q.delete();
        end
    endtask
    initial begin
        int ld, c1, c2, n;
        repeat (3) @(negedge clock);
        chk("rst_expired", expired, 0);
        chk("rst_busy", busy, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_tick", one_hz_enable, 0);
        reset = 1;
        n = 0;
        while (!one_hz_enable && n < 30) begin @(negedge clock); n++; end
        c1 = cyc;
        @(negedge clock);
        n = 0;
        while (!one_hz_enable && n < 30) begin @(negedge clock); n++; end
        c2 = cyc;
        chk("tick_period", c2 - c1, 10);
        chk("idle_busy", busy, 0);
        chk("idle_remaining", remaining, 0);
        start(2'b01, 80, ld);
        chk("drv_busy", busy, 1);
        chk("drv_load", remaining, 8);
        for (int k = 1; k < 8; k++) begin
            wait_cyc(ld + 10 * k);
            chk("drv_remaining", remaining, 8 - k);
        end
        wait_done();
        @(negedge clock);
        chk("drv_after_busy", busy, 0);
        chk("drv_after_remaining", remaining, 0);
        reprogram = 1;
        time_param_sel = 2'b11;
        time_value = 3;
        @(negedge clock);
        reprogram = 0;
        start(2'b11, 30, ld);
        chk("alarm_load", remaining, 3);
        wait_done();
        start(2'b00, 60, ld);
        chk("arm_load", remaining, 6);
        wait_done();
        start(2'b10, 150, ld);
        wait_cyc(ld + 55);
        chk("pass_mid", remaining, 10);
        q.delete();
        start(2'b00, 60, ld);
        chk("restart_load", remaining, 6);
        wait_done();
        repeat (50) @(negedge clock);
        reprogram = 1;
        time_param_sel = 2'b01;
        time_value = 2;
        start(2'b01, 80, ld);
        chk("same_cycle_load", remaining, 8);
        wait_done();
        start(2'b01, 20, ld);
        chk("new_drv_load", remaining, 2);
        wait_done();
        start(2'b10, 150, ld);
        wait_cyc(ld + 110);
        chk("pre_reset_remaining", remaining, 4);
        #2 reset = 0;
        q.delete();
        #1;
        chk("async_busy", busy, 0);
        chk("async_remaining", remaining, 0);
        chk("async_expired", expired, 0);
        chk("async_tick", one_hz_enable, 0);
        repeat (2) @(negedge clock);
        reset = 1;
        @(negedge clock);
        start(2'b11, 100, ld);
        chk("default_alarm_load", remaining, 10);
        wait_done();
        repeat (5) @(negedge clock);
        chk("final_busy", busy, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/timer_antifurto.md
Name: timer_antifurto

Overview:
Countdown timer that sits directly alongside the anti-theft control FSM. It consumes that FSM's start_timer/interval request and returns expired plus the 1 Hz enable strobe. It holds four reprogrammable time parameters, in seconds, and counts the selected one down against an internal 1 Hz tick derived from the system clock. Busy and remaining-seconds outputs drive the status display.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency; the divider terminal count is CLK_FREQ_HZ-1.
TW, 4, width in bits of the time parameters and the countdown.
T_ARM_DEF, 6, reset value of the arming delay, in seconds (interval 00).
T_DRV_DEF, 8, reset value of the driver-door delay (interval 01).
T_PASS_DEF, 15, reset value of the passenger-door delay (interval 10).
T_ALARM_DEF, 10, reset value of the siren-on time (interval 11).

Ports:
clock  in  1  system clock; the only clock.
reset  in  1  asynchronous, active-low reset.
start_timer  in  1  load request from the FSM; level-sensitive.
interval  in  2  parameter select for the load: 00 arm, 01 driver, 10 passenger, 11 alarm.
reprogram  in  1  write strobe for the parameter registers.
time_param_sel  in  2  parameter to write; same encoding as interval.
time_value  in  TW  new value in seconds.
expired  out  1  one-clock pulse when the countdown finishes.
one_hz_enable  out  1  one-clock strobe once per second, free-running.
busy  out  1  high while a countdown is loaded or running.
remaining  out  TW  current countdown value.

Behaviour:
- Reset (reset=0, asynchronous):
  - Parameters return to their *_DEF values.
  - count=0, state=IDLE; expired, busy and one_hz_enable are 0; remaining=0; divider=0.
  - Reset asserted mid-count aborts the count with no expired pulse.
- Divider (sub-module one_hz_gen):
  - Free-running counter 0..CLK_FREQ_HZ-1.
  - one_hz_enable is high for exactly the one clock in which the divider is at terminal count.
  - The divider clears whenever the timer loads, so the first second after a load is a full second.
- State IDLE:
  - busy=0.
  - start_timer=1: count<=param[interval]; go to LOAD.
- State LOAD:
  - busy=1.
  - While start_timer stays 1, count is reloaded every clock (restart semantics).
  - start_timer=0: go to COUNT.
- State COUNT:
  - busy=1.
  - On each one_hz_enable tick: count<=count-1.
  - Tick with count==1, or loaded value 0 (no tick needed): count<=0, go to DONE.
  - start_timer=1 in COUNT: reload from the current interval and go to LOAD. This also applies mid-count.
- State DONE:
  - expired=1 for exactly this one clock; busy=0; go to IDLE.
  - If start_timer=1 in this cycle, the expired pulse is still emitted and the next state is LOAD.
- expired is registered and never asserts outside DONE.
- The count never wraps below 0.
- Reprogram:
  - When reprogram=1, param[time_param_sel]<=time_value at the clock edge.
  - The value is stored as-is; 0 is legal and means "expire immediately after start deasserts".
  - A reprogram in the same cycle as a load of the same parameter: the load uses the old value and the new value applies to later loads.
  - A reprogram never alters a countdown already running.
- remaining mirrors count in LOAD and COUNT, and is 0 in IDLE and DONE.

Optional Feature:
TIMER_TICK_EXT_EN.
- Defined:
  - one_hz_gen is not instantiated.
  - An extra input port tick_in (1 bit) provides the tick and is passed straight to one_hz_enable.
  - No clear-on-load; CLK_FREQ_HZ is ignored.
  - This is used for shared-tick integration and fast simulation.
- Undefined: the internal divider is used as described above, and tick_in does not exist.

Decomposition:
- Shared package antifurto_pkg:
  - interval encodings INT_ARM=2'b00, INT_DRV=2'b01, INT_PASS=2'b10, INT_ALARM=2'b11.
  - timer state encodings IDLE/LOAD/COUNT/DONE.
  - default time constants.
- The package is shared with the control FSM so interval codes have a single source.
- One sub-module: one_hz_gen. Parameter CLK_FREQ_HZ; ports clock, reset, clear, tick.

Test Plan:
1. CLK_FREQ_HZ=10, reset release, no stimulus -> one_hz_enable pulses every 10 clocks; expired=0; busy=0; remaining=0.
2. interval=01, start_timer for 1 clock -> busy=1, remaining counts 8,7,...,1 on successive ticks, expired pulses once 80 clocks after start deasserts, then busy=0.
3. reprogram with sel=11, value=3, then start with interval=11 -> expired 30 clocks later; a second start with interval=00 still uses 6.
4. Start with interval=10 (15 s); after 5 ticks assert start again with interval=00 -> count restarts at 6, and no expired pulse appears for the aborted count.
5. reprogram sel=01, value=2 in the same cycle as start with interval=01 -> this count runs 8 s; the next start runs 2 s.
6. reset=0 at remaining=4 -> outputs are 0 immediately (asynchronously), no expired pulse; parameters read back the default values (the next interval=11 run lasts 10 s).
